// File: rtl/memory_responder_if.sv
// Request/response bundle between the datapath's MAR/MDR port and the memory responder.
interface memory_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Read;
  logic                  Write;
  logic [31:0]           MARdataIn;
  logic [DATA_WIDTH-1:0] MDRdataIn;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  Done;
  logic                  Busy;
  logic                  MemErr;

  modport master (
    output Read, Write, MARdataIn, MDRdataIn,
    input  Mdatain, Done, Busy, MemErr
  );

  modport slave (
    input  Read, Write, MARdataIn, MDRdataIn,
    output Mdatain, Done, Busy, MemErr
  );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed RAM responder with programmable wait states behind the MAR/MDR interface.
// Optional out-of-range flagging is enabled by defining MEM_BOUNDS_CHECK_EN.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  memory_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  op_rd_q, op_rd_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  req_c;
  logic                  access_ok_c;
  logic                  mem_we_c;

  assign req_c = bus.Read | bus.Write;

`ifdef MEM_BOUNDS_CHECK_EN
  // Out-of-range flag is captured with the address and reported alongside Done.
  logic oob_q, oob_d;
  logic memerr_q, memerr_d;

  always_comb begin
    oob_d    = oob_q;
    memerr_d = 1'b0;
    if (state_q == S_IDLE && req_c) begin
      oob_d = |bus.MARdataIn[31:ADDR_WIDTH];
    end
    if (state_q == S_ACCESS) begin
      memerr_d = oob_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      oob_q    <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      oob_q    <= oob_d;
      memerr_q <= memerr_d;
    end
  end

  assign access_ok_c = ~oob_q;
  assign bus.MemErr  = memerr_q;
`else
  logic unused_upper_c;
  assign unused_upper_c = ^bus.MARdataIn[31:ADDR_WIDTH];
  assign access_ok_c    = 1'b1;
  assign bus.MemErr     = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_rd_d  = op_rd_q;
    mdata_d  = mdata_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    mem_we_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          addr_d  = bus.MARdataIn[ADDR_WIDTH-1:0];
          data_d  = bus.MDRdataIn;
          op_rd_d = bus.Read;
          busy_d  = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (access_ok_c) begin
          if (op_rd_q) begin
            mdata_d = mem[addr_q];
          end else begin
            mem_we_c = 1'b1;
          end
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Held request levels must drop before another access can start.
        if (!bus.Read && !bus.Write) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_rd_q <= 1'b0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_rd_q <= op_rd_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // RAM array has no reset; a Clear on the access edge suppresses the write.
  always_ff @(posedge Clock) begin
    if (mem_we_c && !Clear) begin
      mem[addr_q] <= data_q;
    end
  end

  assign bus.Mdatain = mdata_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with default parameters (ADDR_WIDTH=9, WAIT_STATES=2).
module tb_memory_responder;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_err;

  memory_responder_if #(.DATA_WIDTH(32)) bus ();

  memory_responder #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .WAIT_STATES(2)
  ) dut (
    .Clock(clk),
    .Clear(clr),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] DONE_EXP = 5'b01000;
  localparam logic [5:0] BUSY_EXP = 6'b011111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from idle, records Done/Busy/MemErr per edge and Mdatain at the Done cycle.
  task automatic run_op(input logic rd, input logic wr,
                        input logic [31:0] mar, input logic [31:0] mdr,
                        input logic [31:0] mar2, input logic [31:0] mdr2,
                        output logic [4:0] done_h, output logic [5:0] busy_h,
                        output logic [31:0] md, output logic [1:0] me_h);
    done_h = '0;
    busy_h = '0;
    md     = '0;
    me_h   = '0;
    bus.Read      = rd;
    bus.Write     = wr;
    bus.MARdataIn = mar;
    bus.MDRdataIn = mdr;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin
        bus.MARdataIn = mar2;
        bus.MDRdataIn = mdr2;
      end
      if (i < 5) done_h[i] = bus.Done;
      busy_h[i] = bus.Busy;
      if (i == 3) begin
        md        = bus.Mdatain;
        me_h[0]   = bus.MemErr;
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
      end
      if (i == 4) me_h[1] = bus.MemErr;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    step();
    n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Mdatain !== 32'h0) begin n_err++; $display("FAIL reset_mdatain: got %h want 0", bus.Mdatain); end
    n_cmp++; if (bus.MemErr !== 1'b0) begin n_err++; $display("FAIL reset_memerr: got %b want 0", bus.MemErr); end
    clr = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    logic [4:0] dh; logic [5:0] bh; logic [31:0] md; logic [1:0] me;
    run_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, dh, bh, md, me);
    n_cmp++; if (dh !== DONE_EXP) begin n_err++; $display("FAIL wr_done_timing: got %b want %b", dh, DONE_EXP); end
    n_cmp++; if (bh !== BUSY_EXP) begin n_err++; $display("FAIL wr_busy: got %b want %b", bh, BUSY_EXP); end
    n_cmp++; if (md !== 32'h0) begin n_err++; $display("FAIL wr_mdatain_unchanged: got %h want 0", md); end
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, dh, bh, md, me);
    n_cmp++; if (dh !== DONE_EXP) begin n_err++; $display("FAIL rd_done_timing: got %b want %b", dh, DONE_EXP); end
    n_cmp++; if (bh !== BUSY_EXP) begin n_err++; $display("FAIL rd_busy: got %b want %b", bh, BUSY_EXP); end
    n_cmp++; if (md !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", md); end
  endtask

  task automatic test_held_read();
    int   ndone;
    logic busy_all;
    ndone    = 0;
    busy_all = 1'b1;
    bus.Read      = 1'b1;
    bus.Write     = 1'b0;
    bus.MARdataIn = 32'h10;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.Done) ndone++;
      busy_all = busy_all & bus.Busy;
    end
    n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL held_done_count: got %0d want 1", ndone); end
    n_cmp++; if (busy_all !== 1'b1) begin n_err++; $display("FAIL held_busy: got %b want 1", busy_all); end
    bus.Read = 1'b0;
    step();
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL held_release_busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_read_write_both();
    logic [4:0] dh; logic [5:0] bh; logic [31:0] md; logic [1:0] me;
    run_op(1'b0, 1'b1, 32'h20, 32'h0, 32'h20, 32'h0, dh, bh, md, me);
    run_op(1'b1, 1'b1, 32'h20, 32'h1234, 32'h20, 32'h1234, dh, bh, md, me);
    n_cmp++; if (dh !== DONE_EXP) begin n_err++; $display("FAIL both_done_timing: got %b want %b", dh, DONE_EXP); end
    n_cmp++; if (md !== 32'h0) begin n_err++; $display("FAIL both_read_wins: got %h want 0", md); end
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, dh, bh, md, me);
    run_op(1'b1, 1'b0, 32'h20, 32'h0, 32'h20, 32'h0, dh, bh, md, me);
    n_cmp++; if (md !== 32'h0) begin n_err++; $display("FAIL both_no_write: got %h want 0", md); end
  endtask

  task automatic test_clear_mid_write();
    logic [4:0] dh; logic [5:0] bh; logic [31:0] md; logic [1:0] me;
    run_op(1'b0, 1'b1, 32'h30, 32'h11111111, 32'h30, 32'h11111111, dh, bh, md, me);
    bus.Write     = 1'b1;
    bus.MARdataIn = 32'h30;
    bus.MDRdataIn = 32'hCAFEF00D;
    step();
    step();
    clr = 1'b1;
    step();
    n_cmp++; if ({bus.Done, bus.Busy, bus.MemErr} !== 3'b000) begin n_err++; $display("FAIL clr_flags: got %b want 000", {bus.Done, bus.Busy, bus.MemErr}); end
    n_cmp++; if (bus.Mdatain !== 32'h0) begin n_err++; $display("FAIL clr_mdatain: got %h want 0", bus.Mdatain); end
    clr       = 1'b0;
    bus.Write = 1'b0;
    step();
    run_op(1'b1, 1'b0, 32'h30, 32'h0, 32'h30, 32'h0, dh, bh, md, me);
    n_cmp++; if (md !== 32'h11111111) begin n_err++; $display("FAIL clr_write_aborted: got %h want 11111111", md); end
  endtask

  task automatic test_capture();
    logic [4:0] dh; logic [5:0] bh; logic [31:0] md; logic [1:0] me;
    run_op(1'b0, 1'b1, 32'h41, 32'h0, 32'h41, 32'h0, dh, bh, md, me);
    run_op(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 32'h41, 32'hFFFFFFFF, dh, bh, md, me);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h40, 32'h0, dh, bh, md, me);
    n_cmp++; if (md !== 32'hA5A5A5A5) begin n_err++; $display("FAIL cap_wr_addr_data: got %h want a5a5a5a5", md); end
    run_op(1'b1, 1'b0, 32'h41, 32'h0, 32'h41, 32'h0, dh, bh, md, me);
    n_cmp++; if (md !== 32'h0) begin n_err++; $display("FAIL cap_other_addr: got %h want 0", md); end
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h40, 32'h0, dh, bh, md, me);
    n_cmp++; if (md !== 32'hDEADBEEF) begin n_err++; $display("FAIL cap_rd_addr: got %h want deadbeef", md); end
  endtask

  task automatic test_bounds();
    logic [4:0] dh; logic [5:0] bh; logic [31:0] md; logic [1:0] me;
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h40, 32'h0, dh, bh, md, me);
    run_op(1'b1, 1'b0, 32'h210, 32'h0, 32'h210, 32'h0, dh, bh, md, me);
    n_cmp++; if (dh !== DONE_EXP) begin n_err++; $display("FAIL oob_done_timing: got %b want %b", dh, DONE_EXP); end
`ifdef MEM_BOUNDS_CHECK_EN
    n_cmp++; if (me !== 2'b01) begin n_err++; $display("FAIL oob_memerr: got %b want 01", me); end
    n_cmp++; if (md !== 32'hA5A5A5A5) begin n_err++; $display("FAIL oob_rd_suppressed: got %h want a5a5a5a5", md); end
`else
    n_cmp++; if (me !== 2'b00) begin n_err++; $display("FAIL oob_memerr: got %b want 00", me); end
    n_cmp++; if (md !== 32'hDEADBEEF) begin n_err++; $display("FAIL oob_rd_wrap: got %h want deadbeef", md); end
`endif
    run_op(1'b0, 1'b1, 32'h210, 32'h55, 32'h210, 32'h55, dh, bh, md, me);
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, dh, bh, md, me);
`ifdef MEM_BOUNDS_CHECK_EN
    n_cmp++; if (md !== 32'hDEADBEEF) begin n_err++; $display("FAIL oob_wr_suppressed: got %h want deadbeef", md); end
`else
    n_cmp++; if (md !== 32'h55) begin n_err++; $display("FAIL oob_wr_wrap: got %h want 55", md); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr           = 1'b1;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.MARdataIn = '0;
    bus.MDRdataIn = '0;
    test_reset();
    test_write_read();
    test_held_read();
    test_read_write_both();
    test_clear_mid_write();
    test_capture();
    test_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
